// File: rtl/data_mem_init_if.sv
// Port-A/port-B access and status bundle for data_mem_init.
// The master drives the access requests. The slave (the memory) returns read data and status.
interface data_mem_init_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          WriteEn;
    logic          ReInit;
    logic [AW-1:0] DataAddress;
    logic [DW-1:0] DataIn;
    logic [AW-1:0] RdAddrB;
    logic [DW-1:0] DataOut;
    logic [DW-1:0] DataOutB;
    logic          Ready;
    logic          WrDropped;

    modport master (
        output WriteEn, ReInit, DataAddress, DataIn, RdAddrB,
        input  DataOut, DataOutB, Ready, WrDropped
    );

    modport slave (
        input  WriteEn, ReInit, DataAddress, DataIn, RdAddrB,
        output DataOut, DataOutB, Ready, WrDropped
    );
endinterface

// File: rtl/data_mem_init.sv
// Data memory with a sequential init engine: it zero-fills [CLR_BASE, DEPTH-1] and then writes the preload table.
// Define DATA_MEM_SYNC_READ_EN to register both read ports. The default build uses combinational reads.
module data_mem_init #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int CLR_BASE = 64
) (
    input logic           Clk,
    input logic           Reset,
    data_mem_init_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_PRELOAD = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    localparam logic [3:0]    LAST_IDX  = 4'd10;
    localparam logic [AW-1:0] PTR_START = AW'(CLR_BASE);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    logic [DW-1:0] core [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [3:0]    idx_q, idx_d;
    logic          ready_q, ready_d;
    logic          wr_drop_q, wr_drop_d;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    // Address 139 is left out of the table; it keeps the zero written during clear.
    function automatic logic [AW-1:0] preload_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'd130;
            4'd1:    a = 8'd131;
            4'd2:    a = 8'd132;
            4'd3:    a = 8'd133;
            4'd4:    a = 8'd134;
            4'd5:    a = 8'd135;
            4'd6:    a = 8'd136;
            4'd7:    a = 8'd137;
            4'd8:    a = 8'd138;
            4'd9:    a = 8'd140;
            default: a = 8'd141;
        endcase
        return AW'(a);
    endfunction

    function automatic logic [DW-1:0] preload_data(input logic [3:0] idx);
        logic [7:0] d;
        case (idx)
            4'd0:    d = 8'h60;
            4'd1:    d = 8'h48;
            4'd2:    d = 8'h78;
            4'd3:    d = 8'h72;
            4'd4:    d = 8'h6A;
            4'd5:    d = 8'h69;
            4'd6:    d = 8'h5C;
            4'd7:    d = 8'h7E;
            4'd8:    d = 8'h7B;
            4'd9:    d = 8'h20;
            default: d = 8'h00;
        endcase
        return DW'(d);
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        ready_d   = ready_q;
        wr_drop_d = bus.WriteEn && !ready_q;
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = ptr_q;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_PRELOAD;
                    idx_d   = 4'd0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_PRELOAD: begin
                mem_we    = 1'b1;
                mem_addr  = preload_addr(idx_q);
                mem_wdata = preload_data(idx_q);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_READY: begin
                // A write that comes with ReInit still commits; the clear pass then zeroes it if it lies in range.
                mem_we    = bus.WriteEn;
                mem_addr  = bus.DataAddress;
                mem_wdata = bus.DataIn;
                if (bus.ReInit) begin
                    state_d = ST_CLEAR;
                    ptr_d   = PTR_START;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = PTR_START;
                idx_d   = 4'd0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= PTR_START;
            idx_q     <= 4'd0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // The array has no reset. Writes are held off while Reset is low, so words below CLR_BASE survive.
    always_ff @(posedge Clk) begin
        if (Reset && mem_we) begin
            core[mem_addr] <= mem_wdata;
        end
    end

    assign bus.Ready     = ready_q;
    assign bus.WrDropped = wr_drop_q;

`ifdef DATA_MEM_SYNC_READ_EN
    logic [DW-1:0] dout_a_q, dout_a_d;
    logic [DW-1:0] dout_b_q, dout_b_d;

    always_comb begin
        dout_a_d = core[bus.DataAddress];
        dout_b_d = core[bus.RdAddrB];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign bus.DataOut  = dout_a_q;
    assign bus.DataOutB = dout_b_q;
`else
    assign bus.DataOut  = core[bus.DataAddress];
    assign bus.DataOutB = core[bus.RdAddrB];
`endif
endmodule

// File: tb/tb_data_mem_init.sv
// Self-checking bench for data_mem_init: it tests init latency, preload contents, write gating, ReInit and random access.
// It also runs a 16-bit-wide, 512-deep instance to check the parameterised init length.
module tb_data_mem_init;
    localparam int AW_N    = 8;
    localparam int DEPTH_N = 2 ** AW_N;
    localparam int CLR     = 64;
    localparam int LAT_N   = (DEPTH_N - CLR) + 11;
    localparam int LAT_W   = (2 ** 9 - CLR) + 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_init_if #(.DW(8),  .AW(8)) n_if ();
    data_mem_init_if #(.DW(16), .AW(9)) w_if ();

    data_mem_init #(.DW(8), .AW(8), .CLR_BASE(64)) u_dut (
        .Clk(clk), .Reset(rst_n), .bus(n_if)
    );
    data_mem_init #(.DW(16), .AW(9), .CLR_BASE(64)) u_wide (
        .Clk(clk), .Reset(rst_n), .bus(w_if)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mdl [DEPTH_N];
    bit         known [DEPTH_N];
    int         pl_addr [11] = '{130, 131, 132, 133, 134, 135, 136, 137, 138, 140, 141};
    logic [7:0] pl_data [11] = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B, 8'h20, 8'h00};

    // Behavioural effect of a completed init: the top region becomes zero, then the preload table is written.
    task automatic model_init();
        for (int a = CLR; a < DEPTH_N; a++) begin
            mdl[a]   = 8'h00;
            known[a] = 1'b1;
        end
        for (int i = 0; i < 11; i++) mdl[pl_addr[i]] = pl_data[i];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (n_if.Ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic read_ab(input logic [7:0] aa, input logic [7:0] ab,
                           output logic [7:0] da, output logic [7:0] db);
        n_if.DataAddress = aa;
        n_if.RdAddrB     = ab;
`ifdef DATA_MEM_SYNC_READ_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        da = n_if.DataOut;
        db = n_if.DataOutB;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        n_if.WriteEn     = 1'b1;
        n_if.DataAddress = a;
        n_if.DataIn      = d;
        @(posedge clk);
        #1;
        n_if.WriteEn = 1'b0;
        mdl[a]   = d;
        known[a] = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] da, db;
        repeat (3) @(negedge clk);
        vectors++;
        if (n_if.Ready !== 1'b0 || n_if.WrDropped !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: Ready=%b WrDropped=%b, required 0 0", n_if.Ready, n_if.WrDropped);
        end
`ifdef DATA_MEM_SYNC_READ_EN
        vectors++;
        if (n_if.DataOut !== 8'h00 || n_if.DataOutB !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rdata: DataOut=%h DataOutB=%h, required 00 00", n_if.DataOut, n_if.DataOutB);
        end
`endif
        rst_n = 1'b1;
        wait_ready(n);
        vectors++;
        if (n != LAT_N) begin
            miscompares++;
            $display("FAIL init_latency: Ready after %0d edges, required %0d", n, LAT_N);
        end
        model_init();
        for (int a = CLR; a < 142; a++) begin
            read_ab(8'(a), 8'(DEPTH_N - 1 - (a - CLR)), da, db);
            vectors++;
            if (da !== mdl[a] || db !== mdl[DEPTH_N - 1 - (a - CLR)]) begin
                miscompares++;
                $display("FAIL init_contents addr %0d: A=%h B=%h, required %h %h",
                         a, da, db, mdl[a], mdl[DEPTH_N - 1 - (a - CLR)]);
            end
        end
    endtask

    task automatic test_preserve();
        int n;
        logic [7:0] da, db;
        do_write(8'd10, 8'hAB);
        apply_reset();
        wait_ready(n);
        model_init();
        read_ab(8'd10, 8'd10, da, db);
        vectors++;
        if (da !== 8'hAB || db !== 8'hAB) begin
            miscompares++;
            $display("FAIL preserve_low: A=%h B=%h, required ab ab", da, db);
        end
    endtask

    task automatic test_wr_dropped();
        int n;
        logic [7:0] da, db;
        apply_reset();
        @(posedge clk);
        #1;
        n_if.WriteEn     = 1'b1;
        n_if.ReInit      = 1'b1;
        n_if.DataAddress = 8'd200;
        n_if.DataIn      = 8'h55;
        @(posedge clk);
        #1;
        n_if.WriteEn = 1'b0;
        n_if.ReInit  = 1'b0;
        vectors++;
        if (n_if.WrDropped !== 1'b1) begin
            miscompares++;
            $display("FAIL wrdropped_pulse: got %b, required 1", n_if.WrDropped);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (n_if.WrDropped !== 1'b0) begin
            miscompares++;
            $display("FAIL wrdropped_end: got %b, required 0", n_if.WrDropped);
        end
        wait_ready(n);
        vectors++;
        if (n != LAT_N - 3) begin
            miscompares++;
            $display("FAIL reinit_ignored: Ready after %0d more edges, required %0d", n, LAT_N - 3);
        end
        model_init();
        read_ab(8'd200, 8'd200, da, db);
        vectors++;
        if (da !== 8'h00 || db !== 8'h00) begin
            miscompares++;
            $display("FAIL dropped_write: A=%h B=%h, required 00 00", da, db);
        end
    endtask

    task automatic test_reinit_write(input logic [7:0] a);
        int n;
        logic [7:0] da, db;
        n_if.WriteEn     = 1'b1;
        n_if.ReInit      = 1'b1;
        n_if.DataAddress = a;
        n_if.DataIn      = 8'h3C;
        @(posedge clk);
        #1;
        n_if.WriteEn = 1'b0;
        n_if.ReInit  = 1'b0;
        mdl[a]   = 8'h3C;
        known[a] = 1'b1;
        vectors++;
        if (n_if.Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reinit_drop addr %0d: Ready=%b, required 0", a, n_if.Ready);
        end
        wait_ready(n);
        vectors++;
        if (n != LAT_N) begin
            miscompares++;
            $display("FAIL reinit_latency addr %0d: %0d edges, required %0d", a, n, LAT_N);
        end
        model_init();
        read_ab(a, a, da, db);
        vectors++;
        if (da !== mdl[a] || db !== mdl[a]) begin
            miscompares++;
            $display("FAIL reinit_word addr %0d: A=%h B=%h, required %h", a, da, db, mdl[a]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (n_if.Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ready: Ready=%b, required 0", n_if.Ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        vectors++;
        if (n != LAT_N) begin
            miscompares++;
            $display("FAIL mid_reset_latency: %0d edges, required %0d", n, LAT_N);
        end
        model_init();
    endtask

    task automatic test_random();
        logic [7:0] a, d, b, da, db;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 8'($urandom);
                d = 8'($urandom);
                n_if.WriteEn     = 1'b1;
                n_if.DataAddress = a;
                n_if.DataIn      = d;
                n_if.RdAddrB     = a;
                #1;
`ifndef DATA_MEM_SYNC_READ_EN
                if (known[a]) begin
                    vectors++;
                    if (n_if.DataOut !== mdl[a]) begin
                        miscompares++;
                        $display("FAIL old_on_write addr %0d: got %h, required %h", a, n_if.DataOut, mdl[a]);
                    end
                end
`endif
                @(posedge clk);
                #1;
`ifdef DATA_MEM_SYNC_READ_EN
                if (known[a]) begin
                    vectors++;
                    if (n_if.DataOut !== mdl[a] || n_if.DataOutB !== mdl[a]) begin
                        miscompares++;
                        $display("FAIL old_on_write addr %0d: A=%h B=%h, required %h",
                                 a, n_if.DataOut, n_if.DataOutB, mdl[a]);
                    end
                end
`endif
                n_if.WriteEn = 1'b0;
                mdl[a]   = d;
                known[a] = 1'b1;
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                read_ab(a, b, da, db);
                if (known[a]) begin
                    vectors++;
                    if (da !== mdl[a]) begin
                        miscompares++;
                        $display("FAIL rand_read_a addr %0d: got %h, required %h", a, da, mdl[a]);
                    end
                end
                if (known[b]) begin
                    vectors++;
                    if (db !== mdl[b]) begin
                        miscompares++;
                        $display("FAIL rand_read_b addr %0d: got %h, required %h", b, db, mdl[b]);
                    end
                end
            end
            if (n_if.Ready !== 1'b1 || n_if.WrDropped !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL rand_status: Ready=%b WrDropped=%b, required 1 0", n_if.Ready, n_if.WrDropped);
            end
        end
    endtask

    task automatic test_same_addr();
        logic [7:0] da, db;
        do_write(8'd5, 8'h9E);
        read_ab(8'd5, 8'd5, da, db);
        vectors++;
        if (da !== 8'h9E || db !== 8'h9E) begin
            miscompares++;
            $display("FAIL same_addr_read: A=%h B=%h, required 9e 9e", da, db);
        end
    endtask

    task automatic test_wide();
        int n;
        int nn;
        n  = -1;
        nn = -1;
        apply_reset();
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (nn < 0 && n_if.Ready === 1'b1) nn = i;
            if (w_if.Ready === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != LAT_W) begin
            miscompares++;
            $display("FAIL wide_latency: %0d edges, required %0d", n, LAT_W);
        end
        vectors++;
        if (nn != LAT_N) begin
            miscompares++;
            $display("FAIL narrow_latency_beside_wide: %0d edges, required %0d", nn, LAT_N);
        end
        vectors++;
        if (w_if.DataOut !== 16'h0048 || w_if.DataOutB !== 16'h0000) begin
            miscompares++;
            $display("FAIL wide_contents: A=%h B=%h, required 0048 0000", w_if.DataOut, w_if.DataOutB);
        end
        model_init();
    endtask

    initial begin
        n_if.WriteEn = 1'b0;  n_if.ReInit = 1'b0;
        n_if.DataAddress = '0; n_if.DataIn = '0; n_if.RdAddrB = '0;
        w_if.WriteEn = 1'b0;  w_if.ReInit = 1'b0;
        w_if.DataAddress = 9'd131; w_if.DataIn = '0; w_if.RdAddrB = 9'd300;
        for (int a = 0; a < DEPTH_N; a++) begin
            mdl[a]   = 8'h00;
            known[a] = 1'b0;
        end
        test_reset();
        test_preserve();
        test_wr_dropped();
        test_reinit_write(8'd150);
        test_reinit_write(8'd20);
        test_reset_mid();
        test_random();
        test_same_addr();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
